rsa_stream_driver: RTL and testbench
====================================

# rsa_stream_driver

Byte-stream front end for the 256-bit square-and-multiply modular exponentiation engine. The block packs incoming message bytes into one BUS_WIDTH-bit block and latches the key. It drives the engine's one-cycle start handshake, waits for a fresh completion, and serializes the result back out as bytes. It is the initiator side of the engine's ready/valid protocol and sits between the network byte path and the RSA core.

## Interface
- BUS_WIDTH, 256, operand width in bits; power of 2, ≥ 16, multiple of 8
- clk  in  1  system clock, shared with the engine
- reset  in  1  synchronous, active-high; the same net resets the engine
- in_data  in  8  message byte, most significant byte first
- in_valid  in  1  in_data is valid
- in_ready  out  1  driver accepts a byte this cycle
- key_e  in  BUS_WIDTH  exponent; sampled at block start
- key_n  in  BUS_WIDTH  modulus; sampled at block start
- eng_m / eng_e / eng_n  out  BUS_WIDTH each  registered operands to the engine
- eng_ready  out  1  one-cycle start pulse to the engine
- eng_valid  in  1  engine done; level signal, cleared by the engine about 2 cycles after start
- eng_out  in  BUS_WIDTH  engine result
- out_data  out  8  result byte, most significant byte first
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts the byte
- busy  out  1  a block is in flight (state ≠ LOAD)
- err  out  1  sticky range error; see Configuration

## Operation
- States and transitions:
  - LOAD → CHECK (with macro) or START, after the last byte is accepted.
  - CHECK → START if eng_m < key_n, otherwise ZFILL.
  - START → ARM.
  - ARM → WAIT once eng_valid = 0 is seen.
  - WAIT → CAPTURE once eng_valid = 1.
  - CAPTURE → EMIT.
  - EMIT → LOAD after byte BUS_WIDTH/8−1 is accepted.
  - ZFILL behaves like EMIT but emits all-zero data.
- LOAD:
  - in_ready = 1 in this state and not in reset.
  - Each accepted byte shifts into eng_m from the LSB end: eng_m ← {eng_m[BUS_WIDTH-9:0], in_data}.
  - The byte counter (width $clog2(BUS_WIDTH/8)) increments per accepted byte and wraps to 0 on the last byte.
- START:
  - eng_ready = 1 for exactly one cycle.
  - eng_e and eng_n are latched from key_e/key_n on the last-byte acceptance edge.
  - eng_m, eng_e and eng_n hold stable until the next LOAD.
- ARM exists because eng_valid may still be high from the previous block. The driver never captures until it has seen eng_valid low at least once after the start pulse.
- CAPTURE: eng_out is loaded into the output shift register.
- EMIT: out_data is the top byte of the output shift register. The register shifts left 8 on out_valid & out_ready.
- One block is in flight at a time; there is no overlap of input and output.
- eng_valid high during LOAD, START or CAPTURE is ignored.

## Timing
- Reset values: in_ready 0 while reset is high, then 1; eng_ready 0; eng_m, eng_e, eng_n 0; out_valid 0; out_data 0x00; busy 0; err 0. State resets to LOAD and the counter to 0.
- Reset mid-operation discards the partial block and the captured result. No eng_ready is pulsed during or after reset until a full new block has been loaded.
- eng_ready asserts on the cycle after the last input byte is accepted (one cycle later with the macro).
- The earliest CAPTURE is 2 cycles after the end of START; the total latency is engine latency + 3.
- out_valid rises the cycle after CAPTURE and stays high with out_data stable while out_ready = 0.
- The last output byte handshake is followed by LOAD on the next cycle, where in_ready = 1.
- in_valid bubbles and out_ready stalls of any length are tolerated without loss or duplication.

## Configuration
- RSA_DRV_RANGE_CHECK_EN defined:
  - CHECK state is present.
  - If eng_m ≥ key_n or key_n = 0, no engine start is issued, err is set (sticky until reset), and BUS_WIDTH/8 bytes of 0x00 are emitted.
- Undefined:
  - No CHECK or ZFILL state; LOAD goes directly to START.
  - err is tied to 0.
  - Blocks are forwarded unchecked.

## Structure
- Shared package rsa_pkg contains:
  - the BUS_WIDTH default
  - BYTES_PER_BLOCK = BUS_WIDTH/8
  - the driver state enum type
- One sub-module is natural: rsa_byte_shifter, a BUS_WIDTH register with parallel load and shift-by-8. It is instantiated twice, once for input packing (eng_m) and once for output serialization.

## Test plan
- Basic result: BUS_WIDTH = 256 with the real engine; m = 2, e = 3, n = 33 as 32-byte streams → eng_ready pulses once; output is 31 × 0x00 then 0x08.
- Stale completion: engine model holds eng_valid = 1 from block 1 for 2 cycles after the start pulse; block 2 has m = 3 → output ends 0x1B (27), not 0x08.
- Output backpressure: out_ready = 0 for 10 cycles at byte 5 → out_data is held; all 32 bytes arrive in order; in_ready stays 0 until the last byte.
- Input bubbles: in_valid toggled 1/0 every cycle → eng_m is bit-exact to the byte sequence; eng_ready pulses only after 32 accepted bytes.
- Reset during WAIT:
  - One cycle after reset is asserted, all outputs are at their reset values.
  - After reset is released, the next block (m = 2) yields 0x08 correctly.
- Range check, macro defined: m = 33, n = 33 → err = 1; eng_ready never asserts; 32 × 0x00 are emitted. With the macro undefined, the same stimulus pulses eng_ready and err stays 0.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA byte-stream driver: default operand width,
// block size in bytes and the driver state encoding.
package rsa_pkg;

    localparam int BUS_WIDTH_DEFAULT = 256;
    localparam int BYTES_PER_BLOCK   = BUS_WIDTH_DEFAULT / 8;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_CHECK,
        ST_START,
        ST_ARM,
        ST_WAIT,
        ST_CAPTURE,
        ST_EMIT,
        ST_ZFILL
    } drv_state_t;

endpackage

// File: rtl/rsa_byte_shifter.sv
// WIDTH-bit register with parallel load and a left shift by one byte,
// used both to pack the message and to serialize the result.
module rsa_byte_shifter #(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic [7:0]       shift_in,
    output logic [WIDTH-1:0] q
);

    // NOTE: non-blocking assignment keeps every register update in this clock
    // edge ordered correctly against the readers of q in other processes.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the wide data register is reset too, so a reset discards any
            // partially packed block or captured result instead of leaking it.
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= {q[WIDTH-9:0], shift_in};
        end
    end

endmodule

// File: rtl/rsa_stream_driver.sv
// Byte-stream front end for the modular exponentiation engine: packs bytes,
// starts the engine, waits for a fresh result and serializes it back out.
// Optional range check enabled by defining RSA_DRV_RANGE_CHECK_EN.
module rsa_stream_driver
    import rsa_pkg::*;
#(
    parameter int BUS_WIDTH = BUS_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BUS_WIDTH-1:0] key_e,
    input  logic [BUS_WIDTH-1:0] key_n,
    output logic [BUS_WIDTH-1:0] eng_m,
    output logic [BUS_WIDTH-1:0] eng_e,
    output logic [BUS_WIDTH-1:0] eng_n,
    output logic                 eng_ready,
    input  logic                 eng_valid,
    input  logic [BUS_WIDTH-1:0] eng_out,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 err
);

    localparam int NBYTES = BUS_WIDTH / 8;
    localparam int CNT_W  = $clog2(NBYTES);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

    drv_state_t           state;
    logic [CNT_W-1:0]     cnt;
    logic [BUS_WIDTH-1:0] out_shreg;
    logic                 in_fire;
    logic                 out_fire;
    logic                 out_load;
    logic [BUS_WIDTH-1:0] out_load_data;

    assign in_ready = (state == ST_LOAD) && !reset;
    assign in_fire  = in_ready && in_valid;
    assign out_fire = out_valid && out_ready;
    assign busy     = (state != ST_LOAD);
    assign out_data = out_shreg[BUS_WIDTH-1 -: 8];

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        out_load      = (state == ST_CAPTURE);
        out_load_data = eng_out;
`ifdef RSA_DRV_RANGE_CHECK_EN
        if (state == ST_CHECK && !(eng_m < eng_n)) begin
            out_load      = 1'b1;
            out_load_data = '0;
        end
`endif
    end

    rsa_byte_shifter #(.WIDTH(BUS_WIDTH)) u_in_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (1'b0),
        .load_data ('0),
        .shift     (in_fire),
        .shift_in  (in_data),
        .q         (eng_m)
    );

    rsa_byte_shifter #(.WIDTH(BUS_WIDTH)) u_out_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (out_load),
        .load_data (out_load_data),
        .shift     (out_fire),
        .shift_in  (8'h00),
        .q         (out_shreg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_LOAD;
            cnt       <= '0;
            eng_ready <= 1'b0;
            eng_e     <= '0;
            eng_n     <= '0;
            out_valid <= 1'b0;
`ifdef RSA_DRV_RANGE_CHECK_EN
            err       <= 1'b0;
`endif
        end else begin
            eng_ready <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (in_fire) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_BYTE) begin
                            eng_e <= key_e;
                            eng_n <= key_n;
`ifdef RSA_DRV_RANGE_CHECK_EN
                            state <= ST_CHECK;
`else
                            state     <= ST_START;
                            eng_ready <= 1'b1;
`endif
                        end
                    end
                end
`ifdef RSA_DRV_RANGE_CHECK_EN
                ST_CHECK: begin
                    // A zero modulus also fails this compare and is zero-filled.
                    if (eng_m < eng_n) begin
                        state     <= ST_START;
                        eng_ready <= 1'b1;
                    end else begin
                        state     <= ST_ZFILL;
                        out_valid <= 1'b1;
                        err       <= 1'b1;
                    end
                end
`endif
                ST_START: state <= ST_ARM;
                // The previous block's completion may still be asserted here.
                ST_ARM: if (!eng_valid) state <= ST_WAIT;
                ST_WAIT: if (eng_valid) state <= ST_CAPTURE;
                ST_CAPTURE: begin
                    state     <= ST_EMIT;
                    out_valid <= 1'b1;
                end
                ST_EMIT, ST_ZFILL: begin
                    if (out_fire) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_BYTE) begin
                            out_valid <= 1'b0;
                            state     <= ST_LOAD;
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

`ifndef RSA_DRV_RANGE_CHECK_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_stream_driver.sv
// Self-checking bench for rsa_stream_driver with a behavioural exponentiation
// engine; expectations come from plain modular arithmetic.
module tb_rsa_stream_driver;
    import rsa_pkg::*;

    localparam int W       = BUS_WIDTH_DEFAULT;
    localparam int NB      = BYTES_PER_BLOCK;
    localparam int ENG_LAT = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] key_e, key_n;
    logic [W-1:0] eng_m, eng_e, eng_n;
    logic         eng_ready;
    logic         eng_valid;
    logic [W-1:0] eng_out;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         err;

    rsa_stream_driver #(.BUS_WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .key_e     (key_e),
        .key_n     (key_n),
        .eng_m     (eng_m),
        .eng_e     (eng_e),
        .eng_n     (eng_n),
        .eng_ready (eng_ready),
        .eng_valid (eng_valid),
        .eng_out   (eng_out),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit err_exp = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                            input logic [W-1:0] n);
        logic [2*W-1:0] r, x, nn;
        nn = {{W{1'b0}}, n};
        r  = {{(2*W-1){1'b0}}, 1'b1} % nn;
        x  = {{W{1'b0}}, b} % nn;
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = (r * x) % nn;
            x = (x * x) % nn;
        end
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Engine model: result after ENG_LAT cycles; a stale done level stays high
    // until two cycles after the next start pulse.
    logic [W-1:0] eng_res, snap_m, snap_e, snap_n;
    int           eng_tmr;
    logic         eng_run;
    int           pulses = 0;

    always @(negedge clk) begin
        if (reset) begin
            eng_valid <= 1'b0;
            eng_run   <= 1'b0;
            eng_tmr   <= 0;
            eng_out   <= '0;
        end else if (eng_ready) begin
            eng_run <= 1'b1;
            eng_tmr <= 1;
            eng_res <= modexp(eng_m, eng_e, eng_n);
            snap_m  <= eng_m;
            snap_e  <= eng_e;
            snap_n  <= eng_n;
            pulses  <= pulses + 1;
        end else if (eng_run) begin
            eng_tmr <= eng_tmr + 1;
            if (eng_tmr == 2) eng_valid <= 1'b0;
            if (eng_tmr == ENG_LAT) begin
                eng_valid <= 1'b1;
                eng_out   <= eng_res;
                eng_run   <= 1'b0;
            end
        end
    end

    task automatic send_block(input logic [W-1:0] m, input bit bubbles);
        for (int i = NB - 1; i >= 0; i--) begin
            int t;
            t = 0;
            if (bubbles) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_data  = m[i*8 +: 8];
            in_valid = 1'b1;
            while (!in_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                check_int("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic recv_block(output logic [W-1:0] res, input int stall_at);
        int rdy_bad;
        rdy_bad   = 0;
        res       = '0;
        out_ready = 1'b1;
        for (int k = 0; k < NB; k++) begin
            int t;
            int bad;
            logic [7:0] held;
            t   = 0;
            bad = 0;
            while (!out_valid && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (!out_valid) begin
                check_int("out_valid_timeout", 0, 1);
                return;
            end
            if (k == stall_at) begin
                held      = out_data;
                out_ready = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    if (out_data !== held || !out_valid || in_ready) bad++;
                end
                check_int("stall_hold", bad, 0);
                out_ready = 1'b1;
            end
            if (in_ready) rdy_bad++;
            res = {res[W-9:0], out_data};
            @(negedge clk);
        end
        check_int("in_ready_during_emit", rdy_bad, 0);
        check_int("in_ready_after_emit", int'(in_ready), 1);
    endtask

    task automatic run_block(input string name, input logic [W-1:0] m, input logic [W-1:0] e,
                             input logic [W-1:0] n, input logic [W-1:0] expected,
                             input bit bubbles, input int stall_at);
        int p0;
        bit expect_start;
        logic [W-1:0] exp_res;
        logic [W-1:0] res;
        expect_start = 1'b1;
        exp_res      = expected;
`ifdef RSA_DRV_RANGE_CHECK_EN
        if (m >= n) begin
            expect_start = 1'b0;
            exp_res      = '0;
            err_exp      = 1'b1;
        end
`endif
        key_e = e;
        key_n = n;
        p0    = pulses;
        send_block(m, bubbles);
`ifdef RSA_DRV_RANGE_CHECK_EN
        check_int("start_latency_pre", int'(eng_ready), 0);
        @(negedge clk);
        check_int("start_latency", int'(eng_ready), int'(expect_start));
`else
        check_int("start_latency", int'(eng_ready), 1);
`endif
        key_e = rand_w();
        key_n = rand_w();
        recv_block(res, stall_at);
        check(name, res, exp_res);
        repeat (2) @(negedge clk);
        check_int("pulse_count", pulses - p0, int'(expect_start));
        check_int("err", int'(err), int'(err_exp));
        if (expect_start) begin
            check("snap_m", snap_m, m);
            check("snap_e", snap_e, e);
            check("snap_n", snap_n, n);
        end
    endtask

    task automatic check_reset_values();
        check_int("rst_in_ready", int'(in_ready), 0);
        check_int("rst_eng_ready", int'(eng_ready), 0);
        check("rst_eng_m", eng_m, '0);
        check("rst_eng_e", eng_e, '0);
        check("rst_eng_n", eng_n, '0);
        check_int("rst_out_valid", int'(out_valid), 0);
        check_int("rst_out_data", int'(out_data), 0);
        check_int("rst_busy", int'(busy), 0);
        check_int("rst_err", int'(err), 0);
    endtask

    typedef struct {
        logic [W-1:0] m;
        logic [W-1:0] e;
        logic [W-1:0] n;
        logic [W-1:0] exp;
    } vec_t;

    function automatic vec_t mk(input int m, input int e, input int n, input int r);
        vec_t v;
        v.m   = W'(m);
        v.e   = W'(e);
        v.n   = W'(n);
        v.exp = W'(r);
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tbl[6];
        logic [W-1:0] m, e, n;
        int           p;
        int           t;

        // The first two entries run back to back: block 2 must not reuse block 1's result.
        tbl[0] = mk(2, 3, 33, 8);
        tbl[1] = mk(3, 3, 33, 27);
        tbl[2] = mk(5, 2, 7, 4);
        tbl[3] = mk(12, 5, 1000003, 248832);
        tbl[4] = mk(3, 0, 5, 1);
        tbl[5] = mk(32, 2, 33, 1);

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        key_e     = '0;
        key_n     = '0;
        repeat (3) @(negedge clk);
        check_reset_values();
        reset = 1'b0;
        @(negedge clk);
        check_int("in_ready_after_reset", int'(in_ready), 1);

        for (int i = 0; i < 6; i++)
            run_block($sformatf("table_%0d", i), tbl[i].m, tbl[i].e, tbl[i].n, tbl[i].exp, 1'b0, -1);

        run_block("backpressure", W'(2), W'(3), W'(33), W'(8), 1'b0, 5);

        for (int i = 0; i < 5; i++) begin
            n = rand_w();
            n[W-1] = 1'b1;
            n[0]   = 1'b1;
            m = rand_w();
            m[W-1] = 1'b0;
            e = rand_w();
            run_block($sformatf("random_%0d", i), m, e, n, modexp(m, e, n),
                      (i == 0) ? 1'b1 : 1'($urandom_range(0, 1)),
                      (i == 1) ? int'($urandom_range(0, NB - 1)) : -1);
        end

        // Reset while the driver waits for the engine.
        key_e = W'(3);
        key_n = W'(33);
        p = pulses;
        send_block(W'(2), 1'b0);
        t = 0;
        while (pulses == p && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_int("wait_start_seen", int'(pulses != p), 1);
        repeat (3) @(negedge clk);
        check_int("wait_busy", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values();
        reset   = 1'b0;
        err_exp = 1'b0;
        p = pulses;
        repeat (20) @(negedge clk);
        check_int("no_start_after_reset", pulses - p, 0);
        check_int("no_output_after_reset", int'(out_valid), 0);
        run_block("after_reset", W'(2), W'(3), W'(33), W'(8), 1'b0, -1);

        // Out-of-range message: zero-filled with the check, 33^3 mod 33 = 0 without it.
        run_block("range_m_eq_n", W'(33), W'(3), W'(33), W'(0), 1'b0, -1);
        run_block("after_range", W'(2), W'(3), W'(33), W'(8), 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
